// File: rtl/blowfish_decrypt_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : blowfish_decrypt_iter_if
// Purpose  : Block-in / block-out handshake bundle for the iterative Blowfish core.
// Revision : 1.0
// ============================================================================
interface blowfish_decrypt_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ct_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pt_out;

  modport master (
    output in_valid, ct_in, out_ready,
    input  in_ready, out_valid, pt_out
  );

  modport slave (
    input  in_valid, ct_in, out_ready,
    output in_ready, out_valid, pt_out
  );
endinterface
`default_nettype wire

// File: rtl/blowfish_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : blowfish_decrypt_iter
// Purpose  : Iterative Blowfish decryption core, one Feistel round per two clocks
//            using external 1-cycle S-box RAMs. BLOWFISH_DEC_ENC_MODE_EN adds an
//            enc port selecting encryption at accept time.
// Revision : 1.0
// ============================================================================
module blowfish_decrypt_iter #(
  parameter int ROUNDS  = 16,
  parameter int SBOX_AW = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [32*(ROUNDS+2)-1:0] p_array,
`ifdef BLOWFISH_DEC_ENC_MODE_EN
  input  logic                     enc,
`endif
  blowfish_decrypt_iter_if.slave   blk,
  output logic [SBOX_AW-1:0]       s_addr0,
  output logic [SBOX_AW-1:0]       s_addr1,
  output logic [SBOX_AW-1:0]       s_addr2,
  output logic [SBOX_AW-1:0]       s_addr3,
  input  logic [31:0]              s_data0,
  input  logic [31:0]              s_data1,
  input  logic [31:0]              s_data2,
  input  logic [31:0]              s_data3
);

  localparam int         IW      = $clog2(ROUNDS + 2);
  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_ADDR  = 3'd1;
  localparam logic [2:0] C_MIX   = 3'd2;
  localparam logic [2:0] C_FINAL = 3'd3;
  localparam logic [2:0] C_DONE  = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [31:0]   r_xl;
  logic [31:0]   r_xr;
  logic [31:0]   r_addr;
  logic [IW-1:0] r_idx;
  logic [63:0]   r_pt;
  logic [31:0]   w_p [ROUNDS+2];
  logic [31:0]   w_t;
  logic [31:0]   w_f;
  logic [31:0]   w_addr;
  logic [31:0]   w_fin_l;
  logic [31:0]   w_fin_r;
  logic [IW-1:0] w_start;
  logic [IW-1:0] w_idx_nxt;
  logic          w_last;

  for (genvar k = 0; k < ROUNDS + 2; k++) begin : g_parr
    assign w_p[k] = p_array[32*k +: 32];
  end

  assign w_t = r_xl ^ w_p[r_idx];
  assign w_f = ((s_data0 + s_data1) ^ s_data2) + s_data3;

`ifdef BLOWFISH_DEC_ENC_MODE_EN
  logic r_enc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc <= 1'b0;
    end else if (r_state == C_IDLE && blk.in_valid) begin
      r_enc <= enc;
    end
  end

  // Encryption walks P[0..ROUNDS-1] upward and whitens with the top two words.
  assign w_start   = enc ? '0 : IW'(ROUNDS + 1);
  assign w_last    = r_enc ? (r_idx == IW'(ROUNDS - 1)) : (r_idx == IW'(2));
  assign w_idx_nxt = r_enc ? r_idx + 1'b1 : r_idx - 1'b1;
  assign w_fin_l   = r_enc ? w_p[ROUNDS+1] : w_p[0];
  assign w_fin_r   = r_enc ? w_p[ROUNDS]   : w_p[1];
`else
  assign w_start   = IW'(ROUNDS + 1);
  assign w_last    = (r_idx == IW'(2));
  assign w_idx_nxt = r_idx - 1'b1;
  assign w_fin_l   = w_p[0];
  assign w_fin_r   = w_p[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE:  if (blk.in_valid) w_state_nxt = C_ADDR;
      C_ADDR:  w_state_nxt = C_MIX;
      C_MIX:   w_state_nxt = w_last ? C_FINAL : C_ADDR;
      C_FINAL: w_state_nxt = C_DONE;
      C_DONE:  if (blk.out_ready) w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  // Addresses go straight to the RAMs during ADDR so data is back for MIX.
  always_comb begin
    blk.in_ready  = (r_state == C_IDLE);
    blk.out_valid = (r_state == C_DONE);
    w_addr        = (r_state == C_ADDR) ? w_t : r_addr;
  end

  assign s_addr0    = w_addr[31:24];
  assign s_addr1    = w_addr[23:16];
  assign s_addr2    = w_addr[15:8];
  assign s_addr3    = w_addr[7:0];
  assign blk.pt_out = r_pt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xl   <= '0;
      r_xr   <= '0;
      r_addr <= '0;
      r_idx  <= IW'(ROUNDS + 1);
      r_pt   <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (blk.in_valid) begin
            r_xl  <= blk.ct_in[63:32];
            r_xr  <= blk.ct_in[31:0];
            r_idx <= w_start;
          end
        end
        C_ADDR: begin
          r_xl   <= w_t;
          r_addr <= w_t;
        end
        C_MIX: begin
          r_xl  <= r_xr ^ w_f;
          r_xr  <= r_xl;
          r_idx <= w_idx_nxt;
        end
        // The last MIX swapped L/R; pick them back apart while whitening.
        C_FINAL: r_pt <= {r_xr ^ w_fin_l, r_xl ^ w_fin_r};
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blowfish_decrypt_iter.sv
`default_nettype none
// Bench for blowfish_decrypt_iter: pi-derived Blowfish tables and key schedule feed
// the P-array and 1-cycle S-box RAMs; a queue scoreboard holds the expected plaintext.
module tb_blowfish_decrypt_iter;
  localparam int NW = 1042;
  localparam int NL = NW + 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [575:0] p_array = '0;
  logic [7:0]   s_addr0, s_addr1, s_addr2, s_addr3;
  logic [31:0]  s_data0 = '0, s_data1 = '0, s_data2 = '0, s_data3 = '0;
`ifdef BLOWFISH_DEC_ENC_MODE_EN
  logic         enc = 1'b0;
`endif

  blowfish_decrypt_iter_if bif ();

  blowfish_decrypt_iter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p_array (p_array),
`ifdef BLOWFISH_DEC_ENC_MODE_EN
    .enc     (enc),
`endif
    .blk     (bif),
    .s_addr0 (s_addr0),
    .s_addr1 (s_addr1),
    .s_addr2 (s_addr2),
    .s_addr3 (s_addr3),
    .s_data0 (s_data0),
    .s_data1 (s_data1),
    .s_data2 (s_data2),
    .s_data3 (s_data3)
  );

  always #5 clk = ~clk;

  bit [31:0] bn   [4][NL];
  bit [31:0] ip   [18];
  bit [31:0] ibox [4][256];
  bit [31:0] mp   [18];
  bit [31:0] ms   [4][256];
  bit [63:0] sb_q [$];
  int        errors = 0;
  int        checks = 0;
  int        cyc = 0;
  int        acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    s_data0 <= ms[0][s_addr0];
    s_data1 <= ms[1][s_addr1];
    s_data2 <= ms[2][s_addr2];
    s_data3 <= ms[3][s_addr3];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- big-number arithmetic for pi (limb 0 = integer part) ----
  task automatic bn_clear(input int a);
    for (int j = 0; j < NL; j++) bn[a][j] = '0;
  endtask

  task automatic bn_copy(input int d, input int s);
    for (int j = 0; j < NL; j++) bn[d][j] = bn[s][j];
  endtask

  task automatic bn_div(input int a, input int d);
    bit [31:0] rem = '0;
    bit [63:0] cur;
    bit [63:0] q;
    for (int j = 0; j < NL; j++) begin
      cur = {rem, bn[a][j]};
      q = cur / 64'(d);
      bn[a][j] = q[31:0];
      rem = 32'(cur % 64'(d));
    end
  endtask

  task automatic bn_add(input int a, input int b);
    bit [63:0] s;
    bit c = 1'b0;
    for (int j = NL - 1; j >= 0; j--) begin
      s = {32'h0, bn[a][j]} + {32'h0, bn[b][j]} + {63'h0, c};
      bn[a][j] = s[31:0];
      c = s[32];
    end
  endtask

  task automatic bn_sub(input int a, input int b);
    bit [63:0] s;
    bit br = 1'b0;
    for (int j = NL - 1; j >= 0; j--) begin
      s = {32'h1, bn[a][j]} - {32'h0, bn[b][j]} - {63'h0, br};
      bn[a][j] = s[31:0];
      br = ~s[32];
    end
  endtask

  task automatic bn_mul(input int a, input int m);
    bit [63:0] s;
    bit [31:0] c = '0;
    for (int j = NL - 1; j >= 0; j--) begin
      s = {32'h0, bn[a][j]} * 64'(m) + {32'h0, c};
      bn[a][j] = s[31:0];
      c = s[63:32];
    end
  endtask

  function automatic bit bn_zero(input int a);
    for (int j = 0; j < NL; j++) if (bn[a][j] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // atan(1/x) by its alternating series; slot 0 = power, slot 1 = term
  task automatic bn_atan(input int x, input int dst);
    int k = 1;
    bit neg = 1'b1;
    bn_clear(0);
    bn[0][0] = 32'h1;
    bn_div(0, x);
    bn_copy(dst, 0);
    while (!bn_zero(0)) begin
      bn_div(0, x * x);
      bn_copy(1, 0);
      bn_div(1, 2 * k + 1);
      if (neg) bn_sub(dst, 1);
      else     bn_add(dst, 1);
      neg = !neg;
      k++;
    end
  endtask

  // pi = 16 atan(1/5) - 4 atan(1/239); Blowfish tables are its fraction words
  task automatic gen_pi();
    bn_atan(5, 2);
    bn_atan(239, 3);
    bn_mul(2, 4);
    bn_sub(2, 3);
    bn_mul(2, 4);
    for (int j = 0; j < 18; j++) ip[j] = bn[2][j+1];
    for (int s = 0; s < 4; s++)
      for (int e = 0; e < 256; e++) ibox[s][e] = bn[2][19 + 256*s + e];
  endtask

  // ---------------- behavioural Blowfish -------------------------------------
  function automatic bit [31:0] mf(input bit [31:0] x);
    return ((ms[0][x[31:24]] + ms[1][x[23:16]]) ^ ms[2][x[15:8]]) + ms[3][x[7:0]];
  endfunction

  function automatic bit [63:0] m_enc(input bit [63:0] b);
    bit [31:0] l, r, t;
    l = b[63:32];
    r = b[31:0];
    for (int i = 0; i < 16; i++) begin
      l = l ^ mp[i];
      r = r ^ mf(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ mp[16];
    l = l ^ mp[17];
    return {l, r};
  endfunction

  task automatic load_key(input bit [447:0] k, input int len);
    bit [7:0]  kb [56];
    bit [31:0] w;
    bit [63:0] lr = '0;
    int        kp = 0;
    for (int b = 0; b < len; b++) kb[b] = k[8*(len-1-b) +: 8];
    for (int i = 0; i < 18; i++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        w = {w[23:0], kb[kp]};
        kp = (kp + 1) % len;
      end
      mp[i] = ip[i] ^ w;
    end
    for (int s = 0; s < 4; s++)
      for (int e = 0; e < 256; e++) ms[s][e] = ibox[s][e];
    for (int i = 0; i < 18; i += 2) begin
      lr = m_enc(lr);
      mp[i] = lr[63:32];
      mp[i+1] = lr[31:0];
    end
    for (int s = 0; s < 4; s++)
      for (int e = 0; e < 256; e += 2) begin
        lr = m_enc(lr);
        ms[s][e] = lr[63:32];
        ms[s][e+1] = lr[31:0];
      end
    for (int i = 0; i < 18; i++) p_array[32*i +: 32] = mp[i];
  endtask

  // ---------------- stimulus helpers -----------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit [63:0] ct, input bit [63:0] exp, output bit ok);
    int n = 0;
    while (bif.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    ok = (bif.in_ready === 1'b1);
    bif.ct_in = ct;
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    sb_q.push_back(exp);
    acc_cyc = cyc;
  endtask

  task automatic wait_out(output int lat, output bit got);
    int n = 0;
    while (bif.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    got = (bif.out_valid === 1'b1);
    lat = cyc - acc_cyc;
  endtask

  // ---------------- tests -----------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bif.in_ready); end
    checks++;
    if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bif.out_valid); end
    checks++;
    if (bif.pt_out !== 64'h0) begin errors++; $display("FAIL reset_pt_out: got %h want 0", bif.pt_out); end
    checks++;
    if ({s_addr0, s_addr1, s_addr2, s_addr3} !== 32'h0) begin
      errors++; $display("FAIL reset_s_addr: got %h want 0", {s_addr0, s_addr1, s_addr2, s_addr3});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", bif.in_ready, bif.out_valid);
    end
  endtask

  task automatic test_kat();
    bit [63:0] key_tab [2] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF};
    bit [63:0] pt_tab  [2] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF};
    bit [63:0] ct_tab  [2] = '{64'h4EF997456198DD78, 64'h51866FD5B85ECB8A};
    bit [63:0] exp;
    bit [31:0] t;
    bit        ok, got;
    int        lat;
    for (int v = 0; v < 2; v++) begin
      load_key({384'h0, key_tab[v]}, 8);
      checks++;
      if (m_enc(pt_tab[v]) !== ct_tab[v]) begin
        errors++; $display("FAIL kat_model[%0d]: model ct %h want %h", v, m_enc(pt_tab[v]), ct_tab[v]);
      end
      send(ct_tab[v], pt_tab[v], ok);
      t = ct_tab[v][63:32] ^ mp[17];
      checks++;
      if (!ok || {s_addr0, s_addr1, s_addr2, s_addr3} !== t) begin
        errors++; $display("FAIL kat_s_addr[%0d]: ok=%b got %h want %h", v, ok, {s_addr0, s_addr1, s_addr2, s_addr3}, t);
      end
      tick();
      checks++;
      if ({s_addr0, s_addr1, s_addr2, s_addr3} !== t) begin
        errors++; $display("FAIL kat_s_addr_hold[%0d]: got %h want %h", v, {s_addr0, s_addr1, s_addr2, s_addr3}, t);
      end
      wait_out(lat, got);
      checks++;
      if (!got || lat != 33) begin errors++; $display("FAIL kat_latency[%0d]: valid=%b lat=%0d want 33", v, got, lat); end
      exp = sb_q.pop_front();
      checks++;
      if (bif.pt_out !== exp) begin errors++; $display("FAIL kat_pt[%0d]: got %h want %h", v, bif.pt_out, exp); end
      tick();
    end
  endtask

  task automatic test_round_trip();
    bit [63:0] pt = 64'hd5118e9dd5118e9d;
    bit [63:0] exp;
    bit        ok, got;
    int        lat;
    load_key({14{32'hd5118e9d}}, 56);
    send(m_enc(pt), pt, ok);
    wait_out(lat, got);
    checks++;
    if (!ok || !got || lat != 33) begin errors++; $display("FAIL rt_latency: ok=%b valid=%b lat=%0d want 33", ok, got, lat); end
    exp = sb_q.pop_front();
    checks++;
    if (bif.pt_out !== exp) begin errors++; $display("FAIL rt_pt: got %h want %h", bif.pt_out, exp); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit [63:0] pt, exp;
    bit        ok, got;
    int        lat, prev;
    bif.out_ready = 1'b1;
    prev = 0;
    for (int b = 0; b < 3; b++) begin
      pt = {$urandom(), $urandom()};
      send(m_enc(pt), pt, ok);
      if (b > 0) begin
        checks++;
        if (!ok || acc_cyc - prev != 35) begin
          errors++; $display("FAIL b2b_spacing[%0d]: ok=%b spacing=%0d want 35", b, ok, acc_cyc - prev);
        end
      end
      prev = acc_cyc;
      wait_out(lat, got);
      exp = sb_q.pop_front();
      checks++;
      if (!got || bif.pt_out !== exp) begin
        errors++; $display("FAIL b2b_pt[%0d]: valid=%b got %h want %h", b, got, bif.pt_out, exp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit [63:0] pt, ct, exp;
    bit        ok, got, seen;
    int        lat;
    pt = {$urandom(), $urandom()};
    ct = m_enc(pt);
    bif.out_ready = 1'b0;
    send(ct, pt, ok);
    wait_out(lat, got);
    exp = sb_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bif.out_valid !== 1'b1 || bif.pt_out !== exp || bif.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b pt=%h in_ready=%b want 1/%h/0", c, bif.out_valid, bif.pt_out, bif.in_ready, exp);
      end
      if (c == 3) begin
        bif.ct_in = ~ct;
        bif.in_valid = 1'b1;
      end
      tick();
      bif.in_valid = 1'b0;
    end
    bif.out_ready = 1'b1;
    tick();
    checks++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", bif.out_valid, bif.in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bif.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL bp_dropped: out_valid=1 want 0 (pulsed block was accepted)"); end
  endtask

  task automatic test_reset_mid();
    bit [63:0] exp;
    bit        ok, got;
    int        lat;
    load_key(448'h0, 8);
    send(64'h4EF997456198DD78, 64'h0, ok);
    repeat (11) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_flags: out_valid=%b in_ready=%b want 0/1", bif.out_valid, bif.in_ready);
    end
    checks++;
    if (bif.pt_out !== 64'h0 || {s_addr0, s_addr1, s_addr2, s_addr3} !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs: pt=%h s_addr=%h want 0/0", bif.pt_out, {s_addr0, s_addr1, s_addr2, s_addr3});
    end
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(64'h4EF997456198DD78, 64'h0, ok);
    wait_out(lat, got);
    checks++;
    if (!ok || !got || lat != 33) begin errors++; $display("FAIL rst_mid_latency: ok=%b valid=%b lat=%0d want 33", ok, got, lat); end
    exp = sb_q.pop_front();
    checks++;
    if (bif.pt_out !== exp) begin errors++; $display("FAIL rst_mid_pt: got %h want %h", bif.pt_out, exp); end
    tick();
  endtask

`ifdef BLOWFISH_DEC_ENC_MODE_EN
  task automatic test_enc();
    bit [63:0] exp;
    bit        ok, got;
    int        lat;
    load_key(448'h0, 8);
    enc = 1'b1;
    send(64'h0, 64'h4EF997456198DD78, ok);
    enc = 1'b0;
    wait_out(lat, got);
    checks++;
    if (!ok || !got || lat != 33) begin errors++; $display("FAIL enc_latency: ok=%b valid=%b lat=%0d want 33", ok, got, lat); end
    exp = sb_q.pop_front();
    checks++;
    if (bif.pt_out !== exp) begin errors++; $display("FAIL enc_ct: got %h want %h", bif.pt_out, exp); end
    tick();
  endtask
`endif

  initial begin
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    bif.ct_in     = '0;
    gen_pi();
    test_reset();
    test_kat();
    test_round_trip();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef BLOWFISH_DEC_ENC_MODE_EN
    test_enc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
